// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, tag type and free-list state enum
package regfile_pkg;

    localparam int PHYS_COUNT_DEF = 128;
    localparam int ARCH_COUNT_DEF = 32;
    localparam int REG_ADDR_WIDTH = $clog2(PHYS_COUNT_DEF);

    typedef logic [REG_ADDR_WIDTH-1:0] phys_tag_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } fl_state_e;

endpackage

// File: rtl/port_compactor.sv
// rtl/port_compactor.sv - maps a valid vector to per-port prefix offsets and a total count
// Ports:
//   valid  in   N        per-port valid bits
//   offset out  N x CW   number of set valid bits below each port
//   total  out  CW       popcount of valid
module port_compactor #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         valid,
    output logic [N-1:0][CW-1:0] offset,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical register tags (config macro: DOUBLE_FREE_CHECK_EN)
// Ports:
//   clk, async_rst                 clock, asynchronous active-high reset
//   alloc_req     in  ALLOC_PORTS  allocation requests, compacted LSB first
//   alloc_ready   out 1            every request port could be granted this cycle
//   alloc_tag     out per port     granted tag (0 on unrequested ports)
//   reclaim_valid in  RECLAIM_PORTS tag returns, compacted LSB first
//   reclaim_tag   in  per port     returned tag
//   free_count    out              entries currently in the list
//   init_done     out 1            list has been seeded with ARCH_COUNT..PHYS_COUNT-1
//   err           out 1            sticky: a reclaim was dropped
module phys_reg_free_list
    import regfile_pkg::*;
#(
    parameter int PHYS_COUNT    = PHYS_COUNT_DEF,
    parameter int ARCH_COUNT    = ARCH_COUNT_DEF,
    parameter int ALLOC_PORTS   = 4,
    parameter int RECLAIM_PORTS = 4,
    parameter int ADDR_WIDTH    = $clog2(PHYS_COUNT)
) (
    input  logic                                     clk,
    input  logic                                     async_rst,
    input  logic [ALLOC_PORTS-1:0]                   alloc_req,
    output logic                                     alloc_ready,
    output logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]   alloc_tag,
    input  logic [RECLAIM_PORTS-1:0]                 reclaim_valid,
    input  logic [RECLAIM_PORTS-1:0][ADDR_WIDTH-1:0] reclaim_tag,
    output logic [ADDR_WIDTH:0]                      free_count,
    output logic                                     init_done,
    output logic                                     err
);

    localparam int CW_A = $clog2(ALLOC_PORTS + 1);
    localparam int CW_R = $clog2(RECLAIM_PORTS + 1);
    localparam logic [ADDR_WIDTH+1:0] PHYS_W   = (ADDR_WIDTH+2)'(PHYS_COUNT);
    localparam logic [ADDR_WIDTH:0]   CAP      = (ADDR_WIDTH+1)'(PHYS_COUNT - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_TAG = (ADDR_WIDTH+1)'(PHYS_COUNT - 1);
    localparam logic [ADDR_WIDTH:0]   NPORTS   = (ADDR_WIDTH+1)'(ALLOC_PORTS);

    logic [ADDR_WIDTH-1:0] fl_mem [PHYS_COUNT];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   init_idx;
    fl_state_e             state;

    logic [ALLOC_PORTS-1:0][CW_A-1:0]   a_off;
    logic [CW_A-1:0]                    a_total;
    logic [RECLAIM_PORTS-1:0]           acc_valid;
    logic [RECLAIM_PORTS-1:0][CW_R-1:0] r_off;
    logic [CW_R-1:0]                    r_total;
    logic [ADDR_WIDTH:0]                pop_ext;
    logic [ADDR_WIDTH:0]                push_ext;
    logic [ADDR_WIDTH:0]                run;
    logic                               ok;
    logic                               r_err;

    // Pointer add with wrap modulo PHYS_COUNT (offsets never exceed PHYS_COUNT).
    function automatic logic [ADDR_WIDTH-1:0] ptr_add(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ADDR_WIDTH:0]   off);
        logic [ADDR_WIDTH+1:0] s;
        s = {2'b00, base} + {1'b0, off};
        if (s >= PHYS_W)
            s = s - PHYS_W;
        return s[ADDR_WIDTH-1:0];
    endfunction

`ifdef DOUBLE_FREE_CHECK_EN
    logic [PHYS_COUNT-1:0] in_list;
`endif

    port_compactor #(.N(ALLOC_PORTS)) u_alloc_cmp (
        .valid  (alloc_req),
        .offset (a_off),
        .total  (a_total)
    );

    port_compactor #(.N(RECLAIM_PORTS)) u_reclaim_cmp (
        .valid  (acc_valid),
        .offset (r_off),
        .total  (r_total)
    );

    assign alloc_ready = (state == READY) && (count >= NPORTS);
    assign free_count  = count;
    assign pop_ext     = alloc_ready ? (ADDR_WIDTH+1)'(a_total) : '0;
    assign push_ext    = (ADDR_WIDTH+1)'(r_total);

    always_comb begin
        for (int i = 0; i < ALLOC_PORTS; i++)
            alloc_tag[i] = alloc_req[i] ? fl_mem[ptr_add(head, (ADDR_WIDTH+1)'(a_off[i]))] : '0;
    end

    // Filter reclaims in port order; the capacity limit is checked against the
    // post-allocation count plus the reclaims already accepted at lower ports.
    always_comb begin
        acc_valid = '0;
        r_err     = 1'b0;
        ok        = 1'b0;
        run       = count - pop_ext;
        for (int i = 0; i < RECLAIM_PORTS; i++) begin
            ok = 1'b0;
            if (state == READY && reclaim_valid[i]) begin
                ok = (reclaim_tag[i] != '0) && (run < CAP);
`ifdef DOUBLE_FREE_CHECK_EN
                if (in_list[reclaim_tag[i]])
                    ok = 1'b0;
                for (int j = 0; j < RECLAIM_PORTS; j++)
                    if (j < i && acc_valid[j] && reclaim_tag[j] == reclaim_tag[i])
                        ok = 1'b0;
`endif
                if (ok) begin
                    acc_valid[i] = 1'b1;
                    run          = run + 1'b1;
                end else begin
                    r_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= INIT;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            init_idx  <= (ADDR_WIDTH+1)'(ARCH_COUNT);
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    tail     <= ptr_add(tail, (ADDR_WIDTH+1)'(1));
                    count    <= count + 1'b1;
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == LAST_TAG) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    head  <= ptr_add(head, pop_ext);
                    tail  <= ptr_add(tail, push_ext);
                    count <= count - pop_ext + push_ext;
                    if (r_err)
                        err <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            fl_mem[tail] <= init_idx[ADDR_WIDTH-1:0];
        end else begin
            for (int i = 0; i < RECLAIM_PORTS; i++)
                if (acc_valid[i])
                    fl_mem[ptr_add(tail, (ADDR_WIDTH+1)'(r_off[i]))] <= reclaim_tag[i];
        end
    end

`ifdef DOUBLE_FREE_CHECK_EN
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            in_list <= '0;
        end else if (state == INIT) begin
            in_list[init_idx[ADDR_WIDTH-1:0]] <= 1'b1;
        end else begin
            for (int i = 0; i < ALLOC_PORTS; i++)
                if (alloc_ready && alloc_req[i])
                    in_list[alloc_tag[i]] <= 1'b0;
            for (int i = 0; i < RECLAIM_PORTS; i++)
                if (acc_valid[i])
                    in_list[reclaim_tag[i]] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - self-checking bench for phys_reg_free_list
module tb_phys_reg_free_list;

    logic            clk = 1'b0;
    logic            async_rst = 1'b0;
    logic [3:0]      alloc_req = '0;
    logic            alloc_ready;
    logic [3:0][6:0] alloc_tag;
    logic [3:0]      reclaim_valid = '0;
    logic [3:0][6:0] reclaim_tag = '0;
    logic [7:0]      free_count;
    logic            init_done;
    logic            err;

    int n_checks = 0;
    int n_err    = 0;

    phys_reg_free_list dut (
        .clk           (clk),
        .async_rst     (async_rst),
        .alloc_req     (alloc_req),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .reclaim_valid (reclaim_valid),
        .reclaim_tag   (reclaim_tag),
        .free_count    (free_count),
        .init_done     (init_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int q[$], input int t);
        foreach (q[i])
            if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural model: the free list is a plain FIFO queue of tags.
    int fl[$];
    int last_pop[$];
    bit m_done;
    bit m_err;
    int m_itag;

    always @(posedge clk or posedge async_rst) begin
        int pre[$];
        int acc[$];
        int t;
        bit ok;
        if (async_rst) begin
            fl.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            m_itag = 32;
        end else if (!m_done) begin
            fl.push_back(m_itag);
            if (m_itag == 127) m_done = 1'b1;
            m_itag++;
        end else begin
            pre = fl;
            acc.delete();
            if (fl.size() >= 4) begin
                last_pop.delete();
                for (int i = 0; i < 4; i++)
                    if (alloc_req[i]) last_pop.push_back(fl.pop_front());
            end
            for (int i = 0; i < 4; i++) begin
                if (reclaim_valid[i]) begin
                    t  = int'(reclaim_tag[i]);
                    ok = (t != 0) && (fl.size() < 127);
`ifdef DOUBLE_FREE_CHECK_EN
                    if (in_q(pre, t) || in_q(acc, t)) ok = 1'b0;
`endif
                    if (ok) begin
                        fl.push_back(t);
                        acc.push_back(t);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit exp_ready;
        int k;
        exp_ready = m_done && (fl.size() >= 4);
        chk("free_count", int'(free_count), fl.size());
        chk("init_done", int'(init_done), int'(m_done));
        chk("err", int'(err), int'(m_err));
        chk("alloc_ready", int'(alloc_ready), int'(exp_ready));
        if (exp_ready) begin
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (alloc_req[i]) begin
                    chk("alloc_tag", int'(alloc_tag[i]), fl[k]);
                    k++;
                end else begin
                    chk("alloc_tag_idle", int'(alloc_tag[i]), 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        async_rst = 1'b1;
        repeat (3) step();
        chk("rst_free_count", int'(free_count), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_alloc_ready", int'(alloc_ready), 0);
        chk("rst_err", int'(err), 0);
        async_rst = 1'b0;

        repeat (95) step();
        chk("init_not_done_95", int'(init_done), 0);
        step();
        chk("init_done_96", int'(init_done), 1);
        chk("init_count_96", int'(free_count), 96);

        alloc_req = 4'b1111;
        #1;
        chk("first_ready", int'(alloc_ready), 1);
        chk("first_tag0", int'(alloc_tag[0]), 32);
        chk("first_tag1", int'(alloc_tag[1]), 33);
        chk("first_tag2", int'(alloc_tag[2]), 34);
        chk("first_tag3", int'(alloc_tag[3]), 35);
        step();
        step();

        alloc_req = 4'b1010;
        #1;
        chk("sparse_p0", int'(alloc_tag[0]), 0);
        chk("sparse_p1", int'(alloc_tag[1]), 40);
        chk("sparse_p2", int'(alloc_tag[2]), 0);
        chk("sparse_p3", int'(alloc_tag[3]), 41);
        step();
        alloc_req = 4'b0000;
        #1;
        chk("sparse_count", int'(free_count), 86);

        alloc_req = 4'b1111;
        repeat (20) step();
        alloc_req = 4'b0111;
        step();
        alloc_req = 4'b0001;
        #1;
        chk("near_empty_count", int'(free_count), 3);
        chk("near_empty_ready", int'(alloc_ready), 0);
        step();
        chk("near_empty_hold", int'(free_count), 3);

        alloc_req     = 4'b0000;
        reclaim_valid = 4'b1111;
        reclaim_tag   = {7'd35, 7'd34, 7'd33, 7'd32};
        step();
        reclaim_valid = 4'b0111;
        reclaim_tag   = {7'd0, 7'd38, 7'd37, 7'd36};
        step();
        chk("refill_count", int'(free_count), 10);

        alloc_req     = 4'b0011;
        reclaim_valid = 4'b0111;
        reclaim_tag   = {7'd0, 7'd41, 7'd40, 7'd39};
        #1;
        chk("simul_tag0", int'(alloc_tag[0]), 125);
        chk("simul_tag1", int'(alloc_tag[1]), 126);
        step();
        reclaim_valid = 4'b0000;
        alloc_req     = 4'b1111;
        #1;
        chk("simul_count", int'(free_count), 11);
        chk("order_tag0", int'(alloc_tag[0]), 127);
        chk("order_tag1", int'(alloc_tag[1]), 32);
        step();

        // Recycle granted tags for long enough that head and tail wrap.
        repeat (40) begin
            alloc_req     = 4'b1111;
            reclaim_valid = 4'b1111;
            for (int i = 0; i < 4; i++)
                reclaim_tag[i] = 7'(last_pop[i]);
            step();
        end
        alloc_req     = 4'b0000;
        reclaim_valid = 4'b0000;
        #1;
        chk("wrap_count", int'(free_count), 7);

`ifdef DOUBLE_FREE_CHECK_EN
        reclaim_valid  = 4'b0001;
        reclaim_tag[0] = 7'(fl[0]);
        step();
        reclaim_valid = 4'b0000;
        chk("dfree_err", int'(err), 1);
        chk("dfree_count", int'(free_count), 7);
`endif

        reclaim_valid = 4'b0001;
        reclaim_tag   = '0;
        step();
        reclaim_valid = 4'b0000;
        chk("tag0_err", int'(err), 1);
        chk("tag0_count", int'(free_count), 7);

        // Reset in the middle of INIT; reclaims during INIT are ignored.
        async_rst = 1'b1;
        step();
        async_rst     = 1'b0;
        reclaim_valid = 4'b1111;
        reclaim_tag   = {7'd8, 7'd7, 7'd6, 7'd5};
        repeat (20) step();
        chk("mid_init_count", int'(free_count), 20);
        async_rst = 1'b1;
        #1;
        chk("mid_rst_count", int'(free_count), 0);
        chk("mid_rst_err", int'(err), 0);
        step();
        async_rst     = 1'b0;
        reclaim_valid = 4'b0000;
        repeat (96) step();
        chk("restart_done", int'(init_done), 1);
        chk("restart_count", int'(free_count), 96);
        alloc_req = 4'b1111;
        #1;
        chk("restart_tag0", int'(alloc_tag[0]), 32);
        chk("restart_tag3", int'(alloc_tag[3]), 35);
        step();
        alloc_req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
